// File: rtl/pattern_detect.sv
`default_nettype none
// ============================================================================
// Module   : pattern_detect
// Purpose  : Blink-pattern receiver; checks high/low widths and pulse count.
//            Optional first-edge timeout: PATTERN_DETECT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module pattern_detect #(
  parameter int CNT_W    = 32,
  parameter int REP_W    = 8,
  parameter int START_TO = 48000000
) (
  input  logic             hwclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] ontime,
  input  logic [CNT_W-1:0] offtime,
  input  logic [CNT_W-1:0] tol,
  input  logic [REP_W-1:0] reps,
  input  logic             sig_in,
  output logic             busy,
  output logic             match,
  output logic             fail,
  output logic [REP_W-1:0] rep_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HIGH = 3'd1,
    S_MEAS_HIGH = 3'd2,
    S_MEAS_LOW  = 3'd3,
    S_MATCH     = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, s_q, s_dly_q;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W:0]   cnt_x;
  logic [REP_W-1:0] rep_q, rep_d, reps_q, reps_d;
  logic [CNT_W-1:0] lo_on_q, lo_on_d, lo_off_q, lo_off_d;
  logic [CNT_W:0]   hi_on_q, hi_on_d, hi_off_q, hi_off_d;
  logic             final_gap, gap_ok;
  logic             to_fire;

  function automatic logic [CNT_W-1:0] lo_bound(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] t);
    return (t >= v) ? '0 : v - t;
  endfunction

  always_ff @(posedge hwclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      s_q     <= sync1_q;
      s_dly_q <= s_q;
    end
  end

  assign rise = s_q & ~s_dly_q;
  assign fall = ~s_q & s_dly_q;

  // Saturating increment; the zero-extended copy compares against the
  // CNT_W+1 bit upper bounds without wrap.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_x     = {1'b0, cnt_q};
  assign final_gap = (rep_q == reps_q);
  assign gap_ok    = (cnt_q >= lo_off_q) && (cnt_x <= hi_off_q);

`ifdef PATTERN_DETECT_TIMEOUT_EN
  localparam int              TO_W    = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);

  logic [TO_W-1:0] to_q, to_d;

  always_comb begin
    to_d = '0;
    if (state_q == S_WAIT_HIGH) begin
      to_d = to_q + TO_W'(1);
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end

  assign to_fire = (state_q == S_WAIT_HIGH) && (to_q == TO_LAST);
`else
  // Timer not built; START_TO is referenced only to keep it a live parameter.
  assign to_fire = (START_TO < 0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    reps_d   = reps_q;
    lo_on_d  = lo_on_q;
    hi_on_d  = hi_on_q;
    lo_off_d = lo_off_q;
    hi_off_d = hi_off_q;

    case (state_q)
      S_IDLE: begin
        rep_d = '0;
        cnt_d = '0;
        if (enable) begin
          lo_on_d  = lo_bound(ontime, tol);
          hi_on_d  = {1'b0, ontime} + {1'b0, tol};
          lo_off_d = lo_bound(offtime, tol);
          hi_off_d = {1'b0, offtime} + {1'b0, tol};
          reps_d   = reps;
          state_d  = (reps == '0) ? S_MATCH : S_WAIT_HIGH;
        end
      end

      S_WAIT_HIGH: begin
        if (to_fire) begin
          state_d = S_FAIL;
        end else if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = S_MEAS_HIGH;
        end
      end

      S_MEAS_HIGH: begin
        if (cnt_x > hi_on_q) begin
          state_d = S_FAIL;
        end else if (fall) begin
          if (cnt_q < lo_on_q) begin
            state_d = S_FAIL;
          end else begin
            rep_d   = rep_q + REP_W'(1);
            cnt_d   = CNT_W'(1);
            state_d = S_MEAS_LOW;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_MEAS_LOW: begin
        if (final_gap) begin
          // After the last pulse, any further rise is an extra pulse.
          if (rise) begin
            state_d = S_FAIL;
          end else if (cnt_x >= hi_off_q) begin
            state_d = S_MATCH;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (cnt_x > hi_off_q) begin
          state_d = S_FAIL;
        end else if (rise) begin
          if (gap_ok) begin
            cnt_d   = CNT_W'(1);
            state_d = S_MEAS_HIGH;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_MATCH, S_FAIL: begin
        state_d = state_q;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!enable) begin
      state_d = S_IDLE;
      rep_d   = '0;
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rep_q    <= '0;
      reps_q   <= '0;
      lo_on_q  <= '0;
      hi_on_q  <= '0;
      lo_off_q <= '0;
      hi_off_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      reps_q   <= reps_d;
      lo_on_q  <= lo_on_d;
      hi_on_q  <= hi_on_d;
      lo_off_q <= lo_off_d;
      hi_off_q <= hi_off_d;
    end
  end

  assign busy      = (state_q == S_WAIT_HIGH) || (state_q == S_MEAS_HIGH) ||
                     (state_q == S_MEAS_LOW);
  assign match     = (state_q == S_MATCH);
  assign fail      = (state_q == S_FAIL);
  assign rep_count = rep_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_detect
// Purpose  : Directed and randomized checks of pattern_detect against a
//            run-length reference model.
// Revision : 1.0
// ============================================================================
module tb_pattern_detect;

  localparam int CNT_W    = 32;
  localparam int REP_W    = 8;
  localparam int START_TO = 1000;
`ifdef PATTERN_DETECT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             hwclk = 1'b0;
  logic             rst, enable, sig_in;
  logic [CNT_W-1:0] ontime, offtime, tol;
  logic [REP_W-1:0] reps;
  logic             busy, match, fail;
  logic [REP_W-1:0] rep_count;

  int total  = 0;
  int bad    = 0;
  bit cmp_en = 1'b0;

  pattern_detect #(
    .CNT_W   (CNT_W),
    .REP_W   (REP_W),
    .START_TO(START_TO)
  ) dut (
    .hwclk    (hwclk),
    .rst      (rst),
    .enable   (enable),
    .ontime   (ontime),
    .offtime  (offtime),
    .tol      (tol),
    .reps     (reps),
    .sig_in   (sig_in),
    .busy     (busy),
    .match    (match),
    .fail     (fail),
    .rep_count(rep_count)
  );

  always #5 hwclk = ~hwclk;

  // Reference model: decisions are taken from run lengths of the
  // synchronised input (consecutive highs/lows before the current cycle).
  typedef enum int {M_IDLE, M_WAIT, M_HIGH, M_LOW, M_MATCH, M_FAIL} mph_t;
  mph_t   ph = M_IDLE;
  int     m_rc = 0, m_reps = 0;
  bit     m_sy1 = 0, m_s = 0, m_sd = 0;
  longint hi_run = 0, lo_run = 0, waited = 0;
  longint lo_on = 0, hi_on = 0, lo_off = 0, hi_off = 0;

  function automatic longint lo_b(longint v, longint t);
    return (t >= v) ? 0 : v - t;
  endfunction

  always @(posedge hwclk) begin
    bit rise;
    rise = m_s && !m_sd;
    if (rst) begin
      ph = M_IDLE; m_rc = 0; m_sy1 = 0; m_s = 0; m_sd = 0; hi_run = 0; lo_run = 0;
    end else begin
      if (!enable) begin
        ph = M_IDLE; m_rc = 0;
      end else begin
        case (ph)
          M_IDLE: begin
            lo_on  = lo_b(longint'(ontime), longint'(tol));
            hi_on  = longint'(ontime) + longint'(tol);
            lo_off = lo_b(longint'(offtime), longint'(tol));
            hi_off = longint'(offtime) + longint'(tol);
            m_reps = int'(reps);
            m_rc   = 0;
            waited = 0;
            ph     = (reps == 0) ? M_MATCH : M_WAIT;
          end
          M_WAIT: begin
            waited++;
            if (TO_EN && waited >= START_TO) ph = M_FAIL;
            else if (rise) ph = M_HIGH;
          end
          M_HIGH: begin
            if (hi_run > hi_on) ph = M_FAIL;
            else if (!m_s) begin
              if (hi_run < lo_on) ph = M_FAIL;
              else begin m_rc++; ph = M_LOW; end
            end
          end
          M_LOW: begin
            if (m_rc == m_reps) begin
              if (rise) ph = M_FAIL;
              else if (lo_run >= hi_off) ph = M_MATCH;
            end else if (lo_run > hi_off) ph = M_FAIL;
            else if (rise) ph = (lo_run >= lo_off) ? M_HIGH : M_FAIL;
          end
          default: ;
        endcase
      end
      if (m_s) begin hi_run++; lo_run = 0; end
      else begin lo_run++; hi_run = 0; end
      m_sd = m_s; m_s = m_sy1; m_sy1 = sig_in;
    end
  end

  always @(negedge hwclk) begin
    if (cmp_en) begin
      total++;
      if (busy !== (ph inside {M_WAIT, M_HIGH, M_LOW}) || match !== (ph == M_MATCH) ||
          fail !== (ph == M_FAIL) || rep_count !== REP_W'(m_rc)) begin
        bad++;
        if (bad < 20)
          $display("FAIL model t=%0t busy/match/fail/rc got %b%b%b/%0d expected %b%b%b/%0d",
                   $time, busy, match, fail, rep_count,
                   ph inside {M_WAIT, M_HIGH, M_LOW}, ph == M_MATCH, ph == M_FAIL, m_rc);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic drive(input logic v, input int n);
    sig_in = v;
    tick(n);
  endtask

  task automatic arm(input int on, input int off, input int t, input int r);
    ontime  = CNT_W'(on);
    offtime = CNT_W'(off);
    tol     = CNT_W'(t);
    reps    = REP_W'(r);
    enable  = 1'b1;
    tick(1);
  endtask

  task automatic idle_low();
    enable = 1'b0;
    sig_in = 1'b0;
    tick(5);
  endtask

  // Counts negedges until match (which=0) or fail (which=1); -1 on expiry.
  task automatic wait_flag(input int which, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick(1);
      if ((which == 0 && match) || (which == 1 && fail)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic random_trial();
    int on, off, t, r, np, w;
    on  = int'($urandom_range(3, 12));
    off = int'($urandom_range(3, 12));
    t   = int'($urandom_range(0, 3));
    r   = int'($urandom_range(0, 4));
    enable = 1'b0;
    sig_in = 1'($urandom_range(0, 1));
    tick(4);
    arm(on, off, t, r);
    ontime = CNT_W'($urandom_range(1, 20));
    tol    = CNT_W'($urandom_range(0, 20));
    drive(1'b0, int'($urandom_range(1, 8)));
    np = r + int'($urandom_range(0, 1));
    if (np == 0) np = 1;
    for (int p = 0; p < np; p++) begin
      w = on + int'($urandom_range(0, 2 * t + 4)) - (t + 2);
      if (w < 1) w = 1;
      drive(1'b1, w);
      if ($urandom_range(0, 19) == 0) enable = 1'b0;
      if ($urandom_range(0, 29) == 0) begin rst = 1'b1; tick(1); rst = 1'b0; end
      w = off + int'($urandom_range(0, 2 * t + 4)) - (t + 2);
      if (w < 1) w = 1;
      drive(1'b0, w);
    end
    drive(1'b0, off + t + 6);
    enable = 1'b0;
    tick(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; sig_in = 1'b0;
    ontime = '0; offtime = '0; tol = '0; reps = '0;
    tick(3);
    chk("reset_busy", busy, 0);
    chk("reset_match", match, 0);
    chk("reset_fail", fail, 0);
    chk("reset_rc", rep_count, 0);
    cmp_en = 1'b1;
    rst = 1'b0;
    tick(3);

    // Exact pattern
    arm(100, 50, 5, 3);
    for (int p = 1; p <= 3; p++) begin
      drive(1'b1, 100);
      drive(1'b0, 3);
      chk("exact_rc", rep_count, p);
      if (p < 3) drive(1'b0, 47);
    end
    wait_flag(0, 200, n);
    chk("exact_match_latency", n + 3, 58);
    chk("exact_fail", fail, 0);
    idle_low();

    // Short second pulse
    arm(100, 50, 5, 3);
    drive(1'b1, 100);
    drive(1'b0, 50);
    drive(1'b1, 94);
    sig_in = 1'b0;
    wait_flag(1, 20, n);
    chk("short_fail_latency", n, 3);
    chk("short_rc", rep_count, 1);
    idle_low();

    // Held high
    arm(100, 50, 5, 3);
    sig_in = 1'b1;
    wait_flag(1, 200, n);
    chk("long_fail_latency", n, 109);
    idle_low();

    // Gap of 56
    arm(100, 50, 5, 3);
    drive(1'b1, 100);
    drive(1'b0, 56);
    sig_in = 1'b1;
    wait_flag(1, 20, n);
    chk("gap_fail_latency", n, 3);
    chk("gap_rc", rep_count, 1);
    idle_low();

    // Extra fourth pulse
    arm(100, 50, 5, 3);
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 100);
      drive(1'b0, (p < 2) ? 50 : 40);
    end
    sig_in = 1'b1;
    wait_flag(1, 20, n);
    chk("extra_fail_latency", n, 3);
    chk("extra_match", match, 0);
    idle_low();

    // Tolerance swallowing ontime: 1-cycle pulse accepted
    arm(100, 50, 200, 1);
    drive(1'b1, 1);
    drive(1'b0, 3);
    chk("tol_rc", rep_count, 1);
    wait_flag(0, 400, n);
    chk("tol_match_latency", n, 250);
    idle_low();

    // reps == 0
    arm(100, 50, 5, 0);
    chk("reps0_match", match, 1);
    chk("reps0_busy", busy, 0);
    idle_low();

    // Abort in MEAS_LOW
    arm(100, 50, 5, 3);
    drive(1'b1, 100);
    drive(1'b0, 10);
    chk("abort_busy_before", busy, 1);
    enable = 1'b0;
    tick(1);
    chk("abort_busy", busy, 0);
    chk("abort_rc", rep_count, 0);
    tick(60);
    chk("abort_match", match, 0);
    chk("abort_fail", fail, 0);
    idle_low();

    // Reset in MEAS_HIGH
    arm(100, 50, 5, 3);
    drive(1'b1, 20);
    rst = 1'b1;
    enable = 1'b0;
    tick(1);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {match, fail, rep_count}, 0);
    rst = 1'b0;
    idle_low();

    // Re-arm while high: first pulse ignored
    sig_in = 1'b1;
    tick(5);
    arm(100, 50, 5, 1);
    drive(1'b1, 100);
    drive(1'b0, 3);
    chk("rearm_rc_ignored", rep_count, 0);
    chk("rearm_busy", busy, 1);
    drive(1'b0, 47);
    drive(1'b1, 100);
    drive(1'b0, 3);
    chk("rearm_rc", rep_count, 1);
    wait_flag(0, 100, n);
    chk("rearm_match_latency", n + 3, 58);
    idle_low();

    // First-edge timeout
    arm(100, 50, 5, 3);
`ifdef PATTERN_DETECT_TIMEOUT_EN
    wait_flag(1, 1100, n);
    chk("timeout_latency", n, START_TO);
`else
    tick(5000);
    chk("no_timeout_fail", fail, 0);
    chk("no_timeout_busy", busy, 1);
`endif
    idle_low();

    for (int k = 0; k < 60; k++) random_trial();

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_detect.md
Name: pattern_detect

Overview:
- Receive-side counterpart of the LED blink-pattern generator. It watches a single-bit input, such as a debounced button or a photodiode comparator, for a train of high pulses separated by low gaps.
- It checks each high width against ontime and each low width against offtime, both within ±tol cycles, and counts exactly reps pulses.
- It reports match or fail to the keylock control logic.

Parameters:
- CNT_W, 32, width of the duration counters and of ontime/offtime/tol.
- REP_W, 8, width of reps and rep_count.
- START_TO, 48000000, first-edge timeout in hwclk cycles; used only when PATTERN_DETECT_TIMEOUT_EN is defined.

Ports:
- hwclk  in  1  system clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level: high arms and runs detection; low returns the block to IDLE.
- ontime  in  CNT_W  expected high width in cycles; latched at arm.
- offtime  in  CNT_W  expected low width in cycles; latched at arm.
- tol  in  CNT_W  allowed ± deviation in cycles; latched at arm.
- reps  in  REP_W  number of high pulses expected; latched at arm.
- sig_in  in  1  asynchronous pattern input.
- busy  out  1  high in WAIT_HIGH, MEAS_HIGH and MEAS_LOW.
- match  out  1  high while in MATCH.
- fail  out  1  high while in FAIL.
- rep_count  out  REP_W  number of high pulses accepted so far.

Behaviour:
- Reset:
  - Synchronous, active-high, one clock.
  - State goes to IDLE; busy, match and fail go to 0; rep_count, counter and synchroniser flops go to 0.
  - Reset mid-pattern aborts immediately with no match/fail pulse.
- Input path:
  - sig_in passes through a 2-flop synchroniser to give s.
  - s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Pulse widths are measured in cycles of s; input-to-decision latency is 3 cycles.
- Bounds:
  - lo_on = (tol >= ontime) ? 0 : ontime - tol.
  - hi_on = ontime + tol, computed in CNT_W+1 bits, so no wrap.
  - lo_off and hi_off are computed the same way from offtime.
  - The counter saturates at all-ones.
- States:
  - IDLE: outputs 0. If enable, latch ontime/offtime/tol/reps and clear rep_count. Go to MATCH if reps==0, otherwise to WAIT_HIGH.
  - WAIT_HIGH: wait for rise. If s is already high at arm, that pulse is ignored until s falls and rises again. On rise: cnt=1, go to MEAS_HIGH.
  - MEAS_HIGH: cnt++ while s is high.
    - cnt > hi_on → FAIL immediately, without waiting for fall.
    - On fall: if cnt < lo_on → FAIL. Otherwise rep_count++, cnt=1, go to MEAS_LOW.
  - MEAS_LOW: cnt++ while s is low.
    - Non-final gap (rep_count < reps): on rise, if cnt in [lo_off, hi_off] then cnt=1 and go to MEAS_HIGH, else FAIL. cnt > hi_off before any rise → FAIL.
    - Final gap (rep_count == reps): any rise → FAIL (extra pulse). cnt reaching hi_off with s still low → MATCH.
  - MATCH: match=1. FAIL: fail=1. Both hold until enable=0, then go to IDLE next cycle; rep_count is held until then.
- Priority:
  - rst > enable=0 > state logic. Dropping enable in any state gives IDLE next cycle.
  - A rise and a bound violation in the same cycle resolve as FAIL.
  - The same-cycle fall and cnt==hi_on is accepted.

Optional Feature:
- PATTERN_DETECT_TIMEOUT_EN defined:
  - In WAIT_HIGH a separate counter runs from arm.
  - If START_TO cycles elapse with no first rise → FAIL.
  - The timer is not applied after the first pulse.
- Not defined: WAIT_HIGH waits indefinitely, and no timer logic is synthesised.

Test Plan:
- Exact pattern: ontime=100, offtime=50, tol=5, reps=3; drive 3×(100 high, 50 low) → rep_count 1,2,3; match=1 exactly hi_off(55)+3 cycles after the final fall; fail stays 0.
- Short pulse: same config, second high = 94 cycles → fail=1 3 cycles after that fall; rep_count=1.
- Long pulse and gap:
  - First high held → fail=1 when cnt reaches 106, before the fall.
  - Separately, a gap of 56 cycles → fail.
  - Extra fourth pulse starting 40 cycles after the third → fail.
- Tolerance edge: tol=200 ≥ ontime=100 gives lo_on=0; high pulse of 1 cycle accepted. reps=0 → match the cycle after arm.
- Abort:
  - enable dropped mid-MEAS_LOW → IDLE next cycle, busy=0, no match/fail.
  - rst during MEAS_HIGH → all outputs 0 next cycle.
  - Re-arm with s already high → first pulse ignored.
- Timeout (macro defined, START_TO=1000): arm with sig_in low → fail=1 after 1000 cycles. Without the macro, fail stays 0 after 5000 cycles.
